mux_rr_arbiter_8: RTL and testbench
===================================

# mux_rr_arbiter_8

Round-robin packet arbiter that shares one WIDTH-bit 8:1 mux path between eight requesters. Picks one requester, locks the grant until that requester's last beat, and forwards beats through a registered valid/ready output stage. Sits in front of a downstream consumer and drives the select of the 8-way data mux internally, replacing any free-running select logic.

## Interface
- WIDTH, 32, data bus width of every input and the output
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in0..in7  in  WIDTH each  requester data buses
- in_valid  in  8  bit i: requester i presents a beat on in<i>
- in_last  in  8  bit i: current beat of requester i ends its packet
- in_ready  out  8  bit i: beat of requester i accepted this cycle when in_valid[i] also high
- out_data  out  WIDTH  registered forwarded beat
- out_valid  out  1  out_data/out_last/out_src hold a beat
- out_last  out  1  forwarded beat ends its packet
- out_src  out  3  index of requester that produced out_data
- out_ready  in  1  downstream consumes beat when out_valid && out_ready
- busy  out  1  grant locked (state BUSY)
- grant  out  3  currently locked requester; valid while busy=1

## Operation
- States: IDLE, BUSY. Registers: state, grant[2:0], ptr[2:0] (highest-priority index), output stage.
- IDLE: if in_valid != 0, grant <= first i with in_valid[i]=1 scanning ptr, ptr+1, ... mod 8; state <= BUSY. If in_valid == 0, stay IDLE. No beat transferred in IDLE.
- BUSY: in_ready[grant] = (!out_valid || out_ready); all other in_ready bits 0. in_ready is 0 for all bits in IDLE.
- Beat accept (in_valid[grant] && in_ready[grant]): out_data <= in<grant>, out_last <= in_last[grant], out_src <= grant, out_valid <= 1.
- Accepted beat with in_last[grant]=1: state <= IDLE, ptr <= grant+1 mod 8 (7 wraps to 0).
- No accept and out_valid && out_ready: out_valid <= 0. Output fields unchanged while out_valid && !out_ready.
- Grant locked through gaps: in_valid[grant] low in BUSY stalls without losing grant. in_valid/in_last of non-granted requesters ignored.
- Single-beat packet: first beat carries in_last=1.
- No timeout; a requester that never sends last holds the path indefinitely (by design).

## Timing
- Reset (rst_n=0 at clock edge): state IDLE, ptr 0, grant 0, busy 0, out_valid 0, out_data 0, out_last 0, out_src 0, in_ready 0. Reset mid-packet discards the buffered beat and the lock.
- Arbitration: in_valid seen in IDLE at cycle N -> busy=1, grant set at N+1; first beat accepted at N+1 if output slot free; out_valid at N+2.
- Throughput inside a packet: 1 beat/cycle with out_ready held 1 (slot frees and reloads in same cycle).
- Backpressure: out_ready=0 with out_valid=1 -> in_ready[grant]=0 same cycle (combinational from out_valid/out_ready); out_data stable.
- Packet turnaround: last accepted at M -> IDLE at M+1 -> next grant at M+2; one bubble cycle per packet.
- in_ready is combinational from state, grant, out_valid, out_ready only; never from in_valid.

## Test plan
- Reset then idle: rst_n low 2 cycles, in_valid=0 -> all outputs 0, busy stays 0 for 20 cycles.
- Single requester: in_valid=8'h08, 4-beat packet 0xA0..0xA3, last on 0xA3, out_ready=1 -> busy at N+1, out_data 0xA0..0xA3 on consecutive cycles N+2..N+5, out_src=3, out_last only on 0xA3, ptr=4 after.
- Rotation: all eight requesting single-beat packets continuously from reset -> out_src sequence 0,1,2,...,7,0 with one bubble between packets.
- Lock: requesters 1 and 2 active; requester 1 drops in_valid for 3 cycles mid-packet -> grant stays 1, in_ready[2]=0 throughout, requester 2 served only after requester 1's last.
- Backpressure: out_ready=0 for 5 cycles mid-packet -> out_data held, in_ready[grant]=0, no beat lost or duplicated on release.
- Reset mid-packet: rst_n low during beat 2 of a 4-beat packet from requester 6 -> out_valid 0 next cycle, ptr 0; with 0 and 6 requesting afterwards, requester 0 granted first.

Source files
------------

// File: rtl/mux_rr_arbiter_8.sv
// ============================================================================
// Module   : mux_rr_arbiter_8
// Brief    : Round-robin packet arbiter; locks one of eight requesters onto a
//            shared 8:1 data mux and forwards beats through a registered stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_rr_arbiter_8 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [WIDTH-1:0] in5,
    input  logic [WIDTH-1:0] in6,
    input  logic [WIDTH-1:0] in7,
    input  logic [7:0]       in_valid,
    input  logic [7:0]       in_last,
    output logic [7:0]       in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic [2:0]       out_src,
    input  logic             out_ready,
    output logic             busy,
    output logic [2:0]       grant
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       r_state;
    logic [2:0]       r_grant;
    logic [2:0]       r_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic [2:0]       r_out_src;

    logic             w_busy;
    logic             w_slot_free;
    logic             w_accept;
    logic [2:0]       w_pick;
    logic [WIDTH-1:0] w_sel_data;

    assign w_busy      = (r_state == S_BUSY);
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_accept    = w_busy && in_valid[r_grant] && w_slot_free;

    always_comb begin
        w_sel_data = in0;
        case (r_grant)
            3'd0:    w_sel_data = in0;
            3'd1:    w_sel_data = in1;
            3'd2:    w_sel_data = in2;
            3'd3:    w_sel_data = in3;
            3'd4:    w_sel_data = in4;
            3'd5:    w_sel_data = in5;
            3'd6:    w_sel_data = in6;
            default: w_sel_data = in7;
        endcase
    end

    // Scan from farthest to nearest so the nearest requester at or after ptr wins.
    always_comb begin
        w_pick = r_ptr;
        for (int k = 7; k >= 0; k--) begin
            if (in_valid[r_ptr + 3'(k)]) begin
                w_pick = r_ptr + 3'(k);
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (w_busy && w_slot_free) begin
            in_ready[r_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_grant     <= 3'd0;
            r_ptr       <= 3'd0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_src   <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|in_valid) begin
                        r_grant <= w_pick;
                        r_state <= S_BUSY;
                    end
                end
                default: begin
                    if (w_accept && in_last[r_grant]) begin
                        r_state <= S_IDLE;
                        r_ptr   <= r_grant + 3'd1;
                    end
                end
            endcase

            // Output slot reloads in the same cycle it drains to keep full rate.
            if (w_accept) begin
                r_out_data  <= w_sel_data;
                r_out_last  <= in_last[r_grant];
                r_out_src   <= r_grant;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;
    assign busy      = w_busy;
    assign grant     = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter_8.sv
// ============================================================================
// Module   : tb_mux_rr_arbiter_8
// Brief    : Scoreboard bench for mux_rr_arbiter_8.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mux_rr_arbiter_8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din [8];
    logic [7:0]  in_valid;
    logic [7:0]  in_last;
    logic [7:0]  in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic [2:0]  out_src;
    logic        out_ready;
    logic        busy;
    logic [2:0]  grant;

    always #5 clk = ~clk;

    mux_rr_arbiter_8 #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in0      (din[0]),
        .in1      (din[1]),
        .in2      (din[2]),
        .in3      (din[3]),
        .in4      (din[4]),
        .in5      (din[5]),
        .in6      (din[6]),
        .in7      (din[7]),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_src  (out_src),
        .out_ready(out_ready),
        .busy     (busy),
        .grant    (grant)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Per-requester beat memories and progress
    logic [31:0] bdata [8][16];
    logic        blast [8][16];
    int          bcnt  [8];
    int          bidx  [8];
    logic [7:0]  en;
    int          stall_at  [8];
    int          stall_rem [8];

    logic [35:0] exp_q [$];
    logic        mon_en;

    int          cyc;
    logic        s_pop;
    logic        s_busy;
    logic [2:0]  s_grant;
    logic [7:0]  s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_data;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic load_pkt(input int r, input logic [31:0] base, input int n);
        for (int j = 0; j < n; j++) begin
            bdata[r][bcnt[r]] = base + 32'(j);
            blast[r][bcnt[r]] = (j == n - 1);
            exp_q.push_back({3'(r), (j == n - 1), base + 32'(j)});
            bcnt[r]++;
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 8; i++) begin
            in_valid[i] = 1'b0;
            in_last[i]  = 1'b0;
            din[i]      = 32'h0;
            if (en[i] && bidx[i] < bcnt[i]) begin
                if (bidx[i] == stall_at[i] && stall_rem[i] > 0) begin
                    stall_rem[i]--;
                end else begin
                    in_valid[i] = 1'b1;
                    in_last[i]  = blast[i][bidx[i]];
                    din[i]      = bdata[i][bidx[i]];
                end
            end
        end
    endtask

    // One clock: sample/score at negedge, then advance stimulus after posedge.
    task automatic tick();
        logic [7:0]  hs;
        logic [35:0] e;
        @(negedge clk);
        hs          = in_valid & in_ready;
        s_busy      = busy;
        s_grant     = grant;
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_out_data  = out_data;
        s_pop       = 1'b0;
        if (mon_en && out_valid && out_ready) begin
            s_pop = 1'b1;
            if (exp_q.size() == 0) begin
                check_val("sb_unexpected_beat", 64'(out_data), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check_val("sb_data", 64'(out_data), 64'(e[31:0]));
                check_val("sb_last", 64'(out_last), 64'(e[32]));
                check_val("sb_src",  64'(out_src),  64'(e[35:33]));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 8; i++) begin
            if (hs[i]) bidx[i]++;
        end
        drive_inputs();
    endtask

    task automatic clear_stim();
        en = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bcnt[i] = 0; bidx[i] = 0; stall_at[i] = -1; stall_rem[i] = 0;
        end
        exp_q.delete();
        drive_inputs();
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        out_ready = 1'b1;
        clear_stim();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    function automatic logic all_done();
        for (int i = 0; i < 8; i++) begin
            if (en[i] && bidx[i] < bcnt[i]) return 1'b0;
        end
        return exp_q.size() == 0;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (!all_done() && n < budget) begin
            tick();
            n++;
        end
        if (!all_done()) check_val({tag, "_timeout"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int prev;
        int n;
        int pops;
        cyc    = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;

        // Reset then idle
        do_reset();
        tick();
        check_val("rst_out_valid", 64'(s_out_valid), 64'd0);
        check_val("rst_out_data",  64'(s_out_data),  64'd0);
        check_val("rst_out_last",  64'(out_last),    64'd0);
        check_val("rst_out_src",   64'(out_src),     64'd0);
        check_val("rst_in_ready",  64'(s_in_ready),  64'd0);
        check_val("rst_grant",     64'(s_grant),     64'd0);
        check_val("rst_ptr",       64'(dut.r_ptr),   64'd0);
        for (int i = 0; i < 20; i++) begin
            check_val("idle_busy", 64'(s_busy), 64'd0);
            tick();
        end

        // Single requester 3, four beats
        do_reset();
        load_pkt(3, 32'hA0, 4);
        en[3] = 1'b1;
        drive_inputs();
        tick();
        check_val("single_busy_N", 64'(s_busy), 64'd0);
        tick();
        check_val("single_busy_N1",  64'(s_busy),     64'd1);
        check_val("single_grant_N1", 64'(s_grant),    64'd3);
        check_val("single_ready_N1", 64'(s_in_ready), 64'h08);
        check_val("single_oval_N1",  64'(s_out_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("single_consecutive", 64'(s_pop), 64'd1);
        end
        check_val("single_busy_end", 64'(s_busy), 64'd0);
        check_val("single_ptr",  64'(dut.r_ptr), 64'd4);
        check_val("single_left", 64'(exp_q.size()), 64'd0);

        // Rotation: all eight, two single-beat packets each
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++)
                load_pkt(i, 32'hC000_0000 | 32'(k << 4) | 32'(i), 1);
        en = 8'hFF;
        drive_inputs();
        prev = -1;
        n = 0;
        while (!all_done() && n < 200) begin
            tick();
            n++;
            if (s_pop) begin
                if (prev >= 0) check_val("rot_gap", 64'(cyc - prev), 64'd2);
                prev = cyc;
            end
        end
        if (!all_done()) check_val("rot_timeout", 64'(exp_q.size()), 64'd0);

        // Lock: requester 1 stalls mid-packet, requester 2 waits
        do_reset();
        load_pkt(1, 32'h1100, 4);
        load_pkt(2, 32'h2200, 2);
        stall_at[1]  = 2;
        stall_rem[1] = 3;
        en = 8'h06;
        drive_inputs();
        n = 0;
        while (!all_done() && n < 100) begin
            tick();
            n++;
            if (s_busy && bidx[1] < bcnt[1]) begin
                check_val("lock_grant", 64'(s_grant), 64'd1);
                check_val("lock_ready2", 64'(s_in_ready[2]), 64'd0);
            end
        end
        if (!all_done()) check_val("lock_timeout", 64'(exp_q.size()), 64'd0);

        // Backpressure mid-packet on requester 5
        do_reset();
        load_pkt(5, 32'hB0, 6);
        en[5] = 1'b1;
        drive_inputs();
        pops = 0;
        n = 0;
        while (pops < 2 && n < 50) begin
            tick();
            n++;
            if (s_pop) pops++;
        end
        check_val("bp_reached", 64'(pops), 64'd2);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("bp_oval",  64'(s_out_valid),   64'd1);
            check_val("bp_hold",  64'(s_out_data),    64'(exp_q[0][31:0]));
            check_val("bp_ready", 64'(s_in_ready),    64'd0);
        end
        out_ready = 1'b1;
        drain("bp", 50);

        // Reset mid-packet from requester 6
        do_reset();
        load_pkt(6, 32'hD0, 4);
        en[6] = 1'b1;
        drive_inputs();
        n = 0;
        s_pop = 1'b0;
        while (!s_pop && n < 20) begin
            tick();
            n++;
        end
        check_val("mid_first_beat", 64'(s_pop), 64'd1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        clear_stim();
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();
        check_val("mid_oval", 64'(s_out_valid), 64'd0);
        check_val("mid_busy", 64'(s_busy),      64'd0);
        check_val("mid_ptr",  64'(dut.r_ptr),   64'd0);
        load_pkt(0, 32'hE0, 1);
        load_pkt(6, 32'hE6, 1);
        en = 8'h41;
        drive_inputs();
        drain("mid_after", 50);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
